// File: rtl/pipelined_control_unit.sv
// MIPS control decoder with a registered ID/EX control bundle, valid/ready handshake, stall/flush
// and illegal-instruction counting. Optional macro JAL_LINK_EN makes jal write the link register.
module pipelined_control_unit #(
   parameter int unsigned ALUC_W = 4,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [5:0]        op,
   input  logic [5:0]        funct,
   input  logic              stall,
   input  logic              flush,
   output logic              out_valid,
   output logic              reg_write_e,
   output logic              mem_to_reg_e,
   output logic              mem_write_e,
   output logic              branch_e,
   output logic              alu_src_e,
   output logic              reg_dst_e,
   output logic              shamt_con_e,
   output logic              zero_ext_e,
   output logic              jump_e,
   output logic              jr_e,
   output logic              link_e,
   output logic [ALUC_W-1:0] alu_ctrl_e,
   output logic              illegal_e,
   output logic [CNT_W-1:0]  illegal_cnt
);

   localparam int unsigned BundleW = 11 + ALUC_W;

   logic       legal;
   logic       reg_write, mem_to_reg, mem_write, branch, alu_src, reg_dst;
   logic       shamt_con, zero_ext, jump, jr, link;
   logic [3:0] alu4;

   logic [BundleW-1:0] dec_bundle;
   logic [BundleW-1:0] bundle_q;
   logic               valid_q;
   logic               illegal_q;
   logic [CNT_W-1:0]   cnt_q;

   always_comb begin
      legal      = 1'b1;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
      mem_write  = 1'b0;
      branch     = 1'b0;
      alu_src    = 1'b0;
      reg_dst    = 1'b0;
      shamt_con  = 1'b0;
      zero_ext   = 1'b0;
      jump       = 1'b0;
      jr         = 1'b0;
      link       = 1'b0;
      alu4       = 4'b0000;
      case (op)
         6'h00: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            case (funct)
               6'h20, 6'h21: alu4 = 4'b0010;
               6'h22, 6'h23: alu4 = 4'b0110;
               6'h24:        alu4 = 4'b0000;
               6'h25:        alu4 = 4'b0001;
               6'h26:        alu4 = 4'b0011;
               6'h27:        alu4 = 4'b1100;
               6'h2a:        alu4 = 4'b0111;
               6'h00: begin alu4 = 4'b0100; shamt_con = 1'b1; end
               6'h02: begin alu4 = 4'b0101; shamt_con = 1'b1; end
               6'h03: begin alu4 = 4'b1000; shamt_con = 1'b1; end
               6'h04:        alu4 = 4'b0100;
               6'h06:        alu4 = 4'b0101;
               6'h07:        alu4 = 4'b1000;
               6'h08: begin alu4 = 4'b1110; jr = 1'b1; reg_write = 1'b0; end
               default:      legal = 1'b0;
            endcase
         end
         6'h08, 6'h09: begin reg_write = 1'b1; alu_src = 1'b1; alu4 = 4'b0010; end
         6'h0c: begin reg_write = 1'b1; alu_src = 1'b1; zero_ext = 1'b1; alu4 = 4'b0000; end
         6'h0d: begin reg_write = 1'b1; alu_src = 1'b1; zero_ext = 1'b1; alu4 = 4'b0001; end
         6'h0e: begin reg_write = 1'b1; alu_src = 1'b1; zero_ext = 1'b1; alu4 = 4'b0011; end
         6'h23: begin reg_write = 1'b1; alu_src = 1'b1; mem_to_reg = 1'b1; alu4 = 4'b0010; end
         6'h2b: begin mem_write = 1'b1; alu_src = 1'b1; alu4 = 4'b0010; end
         6'h04: begin branch = 1'b1; alu4 = 4'b1001; end
         6'h05: begin branch = 1'b1; alu4 = 4'b1010; end
         6'h02: begin jump = 1'b1; alu4 = 4'b1101; end
`ifdef JAL_LINK_EN
         6'h03: begin jump = 1'b1; reg_write = 1'b1; link = 1'b1; alu4 = 4'b1101; end
`else
         6'h03: begin jump = 1'b1; alu4 = 4'b1101; end
`endif
         default: legal = 1'b0;
      endcase
   end

   assign dec_bundle = {reg_write, mem_to_reg, mem_write, branch, alu_src, reg_dst,
                        shamt_con, zero_ext, jump, jr, link, ALUC_W'(alu4)};

   assign in_ready = ~stall;

   // Flush outranks stall so a squashed slot never survives as a held instruction.
   always_ff @(posedge clk) begin
      if (reset) begin
         bundle_q  <= '0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else if (flush) begin
         bundle_q  <= '0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else if (stall) begin
         illegal_q <= 1'b0;
      end else if (in_valid && legal) begin
         bundle_q  <= dec_bundle;
         valid_q   <= 1'b1;
         illegal_q <= 1'b0;
      end else if (in_valid) begin
         bundle_q  <= '0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b1;
         if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + CNT_W'(1);
      end else begin
         bundle_q  <= '0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
      end
   end

   assign {reg_write_e, mem_to_reg_e, mem_write_e, branch_e, alu_src_e, reg_dst_e,
           shamt_con_e, zero_ext_e, jump_e, jr_e} = bundle_q[BundleW-1:ALUC_W+1];
`ifdef JAL_LINK_EN
   assign link_e = bundle_q[ALUC_W];
`else
   assign link_e = 1'b0;
`endif
   assign alu_ctrl_e  = bundle_q[ALUC_W-1:0];
   assign out_valid   = valid_q;
   assign illegal_e   = illegal_q;
   assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench: a table-driven reference model predicts every registered output, a monitor
// compares them each cycle. Honours JAL_LINK_EN the same way the design does.
module tb_pipelined_control_unit;

   localparam int unsigned ALUC_W = 5;
   localparam int unsigned CNT_W  = 2;
   localparam int          CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1, in_valid = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [5:0]        op = '0, funct = '0;
   logic              in_ready, out_valid, reg_write_e, mem_to_reg_e, mem_write_e, branch_e;
   logic              alu_src_e, reg_dst_e, shamt_con_e, zero_ext_e, jump_e, jr_e, link_e;
   logic [ALUC_W-1:0] alu_ctrl_e;
   logic              illegal_e;
   logic [CNT_W-1:0]  illegal_cnt;

   pipelined_control_unit #(.ALUC_W(ALUC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .funct(funct), .stall(stall), .flush(flush), .out_valid(out_valid),
      .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
      .branch_e(branch_e), .alu_src_e(alu_src_e), .reg_dst_e(reg_dst_e),
      .shamt_con_e(shamt_con_e), .zero_ext_e(zero_ext_e), .jump_e(jump_e), .jr_e(jr_e),
      .link_e(link_e), .alu_ctrl_e(alu_ctrl_e), .illegal_e(illegal_e),
      .illegal_cnt(illegal_cnt)
   );

   always #5 clk = ~clk;

   // Control word: {rw, m2r, mw, br, asrc, rdst, shamt, zext, j, jr, link, alu[3:0]}
   logic [14:0] r_tab [int];
   logic [14:0] i_tab [int];

   function automatic logic [14:0] ctl(input bit rw, m2r, mw, br, asrc, rdst, sh, ze, j, jr,
                                       lk, input logic [3:0] alu);
      return {rw, m2r, mw, br, asrc, rdst, sh, ze, j, jr, lk, alu};
   endfunction

   typedef struct {
      logic [16:0] vec;   // {valid, control word, illegal}
      int          cnt;
      bit          ready;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] m_bundle = '0;  // {valid, control word}
   int          m_cnt    = 0;
   int          total    = 0;
   int          bad      = 0;

   task automatic drive(input bit rst, input bit v, input logic [5:0] o, input logic [5:0] f,
                        input bit st, input bit fl);
      exp_t e;
      logic [14:0] w;
      bit found;
      bit ill;
      @(negedge clk);
      reset = rst; in_valid = v; op = o; funct = f; stall = st; flush = fl;
      ill = 1'b0;
      if (rst) begin
         m_bundle = '0;
         m_cnt    = 0;
      end else if (fl) begin
         m_bundle = '0;
      end else if (st) begin
         m_bundle = m_bundle;
      end else if (v) begin
         found = (o == 6'h00) ? r_tab.exists(int'(f)) : i_tab.exists(int'(o));
         if (found) begin
            w        = (o == 6'h00) ? r_tab[int'(f)] : i_tab[int'(o)];
            m_bundle = {1'b1, w};
         end else begin
            m_bundle = '0;
            ill      = 1'b1;
            if (m_cnt < CNT_MAX) m_cnt++;
         end
      end else begin
         m_bundle = '0;
      end
      e.vec   = {m_bundle, ill};
      e.cnt   = m_cnt;
      e.ready = !st;
      exp_q.push_back(e);
   endtask

   always @(posedge clk) begin
      exp_t e;
      logic [16:0] act;
      #1;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         act = {out_valid, reg_write_e, mem_to_reg_e, mem_write_e, branch_e, alu_src_e,
                reg_dst_e, shamt_con_e, zero_ext_e, jump_e, jr_e, link_e, alu_ctrl_e[3:0],
                illegal_e};
         total++;
         if (act !== e.vec) begin
            bad++;
            $display("FAIL bundle op=%h funct=%h got=%b want=%b", op, funct, act, e.vec);
         end
         total++;
         if (alu_ctrl_e[ALUC_W-1:4] !== '0) begin
            bad++;
            $display("FAIL alu_ext got=%b want=0", alu_ctrl_e[ALUC_W-1:4]);
         end
         total++;
         if (illegal_cnt !== CNT_W'(e.cnt)) begin
            bad++;
            $display("FAIL illegal_cnt got=%0d want=%0d", illegal_cnt, e.cnt);
         end
         total++;
         if (in_ready !== e.ready) begin
            bad++;
            $display("FAIL in_ready got=%b want=%b", in_ready, e.ready);
         end
      end
   end

   initial begin
      logic [5:0] lop [11];
      logic [5:0] lfn [16];
      logic [5:0] o, f;
      r_tab[32'h20] = ctl(1,0,0,0,0,1,0,0,0,0,0,4'b0010);
      r_tab[32'h21] = ctl(1,0,0,0,0,1,0,0,0,0,0,4'b0010);
      r_tab[32'h22] = ctl(1,0,0,0,0,1,0,0,0,0,0,4'b0110);
      r_tab[32'h23] = ctl(1,0,0,0,0,1,0,0,0,0,0,4'b0110);
      r_tab[32'h24] = ctl(1,0,0,0,0,1,0,0,0,0,0,4'b0000);
      r_tab[32'h25] = ctl(1,0,0,0,0,1,0,0,0,0,0,4'b0001);
      r_tab[32'h26] = ctl(1,0,0,0,0,1,0,0,0,0,0,4'b0011);
      r_tab[32'h27] = ctl(1,0,0,0,0,1,0,0,0,0,0,4'b1100);
      r_tab[32'h2a] = ctl(1,0,0,0,0,1,0,0,0,0,0,4'b0111);
      r_tab[32'h00] = ctl(1,0,0,0,0,1,1,0,0,0,0,4'b0100);
      r_tab[32'h02] = ctl(1,0,0,0,0,1,1,0,0,0,0,4'b0101);
      r_tab[32'h03] = ctl(1,0,0,0,0,1,1,0,0,0,0,4'b1000);
      r_tab[32'h04] = ctl(1,0,0,0,0,1,0,0,0,0,0,4'b0100);
      r_tab[32'h06] = ctl(1,0,0,0,0,1,0,0,0,0,0,4'b0101);
      r_tab[32'h07] = ctl(1,0,0,0,0,1,0,0,0,0,0,4'b1000);
      r_tab[32'h08] = ctl(0,0,0,0,0,1,0,0,0,1,0,4'b1110);
      i_tab[32'h08] = ctl(1,0,0,0,1,0,0,0,0,0,0,4'b0010);
      i_tab[32'h09] = ctl(1,0,0,0,1,0,0,0,0,0,0,4'b0010);
      i_tab[32'h0c] = ctl(1,0,0,0,1,0,0,1,0,0,0,4'b0000);
      i_tab[32'h0d] = ctl(1,0,0,0,1,0,0,1,0,0,0,4'b0001);
      i_tab[32'h0e] = ctl(1,0,0,0,1,0,0,1,0,0,0,4'b0011);
      i_tab[32'h23] = ctl(1,1,0,0,1,0,0,0,0,0,0,4'b0010);
      i_tab[32'h2b] = ctl(0,0,1,0,1,0,0,0,0,0,0,4'b0010);
      i_tab[32'h04] = ctl(0,0,0,1,0,0,0,0,0,0,0,4'b1001);
      i_tab[32'h05] = ctl(0,0,0,1,0,0,0,0,0,0,0,4'b1010);
      i_tab[32'h02] = ctl(0,0,0,0,0,0,0,0,1,0,0,4'b1101);
`ifdef JAL_LINK_EN
      i_tab[32'h03] = ctl(1,0,0,0,0,0,0,0,1,0,1,4'b1101);
`else
      i_tab[32'h03] = ctl(0,0,0,0,0,0,0,0,1,0,0,4'b1101);
`endif
      lop = '{6'h00, 6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02};
      lfn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h00, 6'h02,
              6'h03, 6'h04, 6'h06, 6'h07, 6'h08};

      // Directed: reset, add, lw held under stall, flush+stall bubble, illegal saturation, jal.
      drive(1, 0, 6'h00, 6'h00, 0, 0);
      drive(1, 0, 6'h00, 6'h00, 0, 0);
      drive(0, 1, 6'h00, 6'h20, 0, 0);
      drive(0, 1, 6'h23, 6'h00, 0, 0);
      repeat (3) drive(0, 1, 6'h2b, 6'h00, 1, 0);
      drive(0, 1, 6'h04, 6'h00, 1, 1);
      drive(0, 1, 6'h3f, 6'h00, 0, 0);
      drive(0, 0, 6'h00, 6'h00, 0, 0);
      repeat (4) drive(0, 1, 6'h3f, 6'h11, 0, 0);
      drive(0, 1, 6'h03, 6'h00, 0, 0);
      drive(0, 1, 6'h00, 6'h01, 1, 0);
      drive(1, 1, 6'h00, 6'h20, 1, 1);

      for (int i = 0; i < 600; i++) begin
         o = ($urandom_range(0, 3) != 0) ? lop[$urandom_range(0, 10)] : 6'($urandom);
         if (i % 5 == 0) o = 6'h03;
         f = ($urandom_range(0, 3) != 0) ? lfn[$urandom_range(0, 15)] : 6'($urandom);
         drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, o, f,
               $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      end

      @(negedge clk);
      @(negedge clk);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain got=%0d pending want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
